// File: rtl/timer_display_if.sv
// Signal bundle between the game timer, timer_display and the board display pins.
// There is no valid/ready handshake: the master holds start/min/sec1/sec2 as levels that the
// slave samples every clk, and the slave drives its registered outputs every clk.
interface timer_display_if;
  logic       start;
  logic [3:0] min;
  logic [3:0] sec1;
  logic [3:0] sec2;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       time_up;
  logic [1:0] dbg_idx;

  modport master (
    output start, min, sec1, sec2,
    input  seg, dp, an, time_up, dbg_idx
  );

  modport slave (
    input  start, min, sec1, sec2,
    output seg, dp, an, time_up, dbg_idx
  );
endinterface

// File: rtl/timer_display.sv
// Glitch-filtered 4-digit multiplexed 7-segment driver for the countdown timer.
// Optional macro TIMEUP_BLINK_EN blanks the display every other half blink period while time_up.
module timer_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 2**24
) (
  input  logic            clk,
  input  logic            rst,
  timer_display_if.slave  bus
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (REFRESH_DIV < 2 || BLINK_DIV < 2 || (BLINK_DIV % 2) != 0) begin : g_bad_param
    $error("timer_display: REFRESH_DIV must be >= 2 and BLINK_DIV must be even and >= 2");
  end

  typedef enum logic [1:0] {
    DIG_SEC2  = 2'd0,
    DIG_SEC1  = 2'd1,
    DIG_MIN   = 2'd2,
    DIG_BLANK = 2'd3
  } digit_e;

  digit_e        r_idx;
  digit_e        w_idx_next;
  logic [SW-1:0] r_slot;
  logic          w_wrap;

  logic [11:0]   w_in;
  logic [11:0]   r_s0;
  logic [11:0]   r_s1;
  logic [11:0]   r_cap;

  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;
  logic          r_time_up;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;
  logic [3:0]    w_an_next;
  logic          w_time_up_next;
  logic          w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // A value reaches r_cap only after two consecutive equal samples, so 1-cycle glitches are dropped.
  assign w_in = {bus.min, bus.sec1, bus.sec2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0  <= '0;
      r_s1  <= '0;
      r_cap <= '0;
    end else begin
      r_s0 <= w_in;
      r_s1 <= r_s0;
      if (r_s0 == r_s1) begin
        r_cap <= r_s0;
      end
    end
  end

  assign w_wrap = (r_slot == SW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot <= '0;
    end else if (w_wrap) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= DIG_SEC2;
    end else begin
      r_idx <= w_idx_next;
    end
  end

  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) begin
      case (r_idx)
        DIG_SEC2:  w_idx_next = DIG_SEC1;
        DIG_SEC1:  w_idx_next = DIG_MIN;
        DIG_MIN:   w_idx_next = DIG_BLANK;
        DIG_BLANK: w_idx_next = DIG_SEC2;
        default:   w_idx_next = DIG_SEC2;
      endcase
    end
  end

  // Outputs follow the next index so an/seg/dp change on the same edge the index does.
  always_comb begin
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    w_an_next  = 4'hF;
    case (w_idx_next)
      DIG_SEC2: begin
        w_an_next  = 4'b1110;
        w_seg_next = f_decode(r_cap[3:0]);
      end
      DIG_SEC1: begin
        w_an_next  = 4'b1101;
        w_seg_next = f_decode(r_cap[7:4]);
      end
      DIG_MIN: begin
        w_an_next  = 4'b1011;
        w_seg_next = f_decode(r_cap[11:8]);
        w_dp_next  = 1'b0;
      end
      DIG_BLANK: begin
        w_an_next  = 4'b0111;
      end
      default: begin
        w_an_next  = 4'hF;
      end
    endcase
  end

  assign w_time_up_next = bus.start & (r_cap == 12'h000);

`ifdef TIMEUP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] r_blink;
  logic [BW-1:0] w_blink_next;

  // Held at zero outside time_up so the first half-period after time_up rises is lit.
  always_comb begin
    w_blink_next = '0;
    if (r_time_up) begin
      w_blink_next = (r_blink == BW'(BLINK_DIV - 1)) ? '0 : r_blink + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink <= '0;
    end else begin
      r_blink <= w_blink_next;
    end
  end

  assign w_blank = r_time_up & (w_blink_next >= BW'(BLINK_DIV / 2));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_an      <= 4'hF;
      r_time_up <= 1'b0;
    end else begin
      r_seg     <= w_seg_next;
      r_dp      <= w_dp_next;
      r_an      <= w_blank ? 4'hF : w_an_next;
      r_time_up <= w_time_up_next;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.an      = r_an;
  assign bus.time_up = r_time_up;
  assign bus.dbg_idx = r_idx;

endmodule
